// File: rtl/i2c_pkg.sv
// Shared I2C definitions: controller FSM states, transfer direction codes and address width.
// The existing target block imports this package as well.
package i2c_pkg;

  localparam int   ADDR_W   = 7;
  localparam logic RW_WRITE = 1'b0;
  localparam logic RW_READ  = 1'b1;

  typedef enum logic [3:0] {
    IDLE,
    START,
    ADDR,
    ADDR_ACK,
    WRITE,
    WRITE_ACK,
    READ,
    READ_NACK,
    STOP
  } state_t;

endpackage

// File: rtl/i2c_tick_gen.sv
// Quarter-bit timebase: divides clk by CLK_DIV and counts the four quarters of an SCL bit slot.
// Held at zero while the controller is idle so every transaction starts on a slot boundary.
module i2c_tick_gen #(
  parameter int CLK_DIV = 4
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_clear,
  output logic       o_qtick,
  output logic [1:0] o_quarter
);

  localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  logic [CW-1:0] r_cnt;
  logic [1:0]    r_quarter;
  logic          w_qtick;

  assign w_qtick   = (r_cnt == CW'(CLK_DIV - 1));
  assign o_qtick   = w_qtick;
  assign o_quarter = r_quarter;

  // The quarter index wraps from 3 to 0 exactly at the slot boundary the FSM acts on.
  always_ff @(posedge i_clk) begin
    if (!i_rst || i_clear) begin
      r_cnt     <= '0;
      r_quarter <= 2'd0;
    end else if (w_qtick) begin
      r_cnt     <= '0;
      r_quarter <= r_quarter + 2'd1;
    end else begin
      r_cnt <= r_cnt + CW'(1);
    end
  end

endmodule

// File: rtl/i2c_controller.sv
// Single-byte I2C master: START, address+rw, one data byte (write with ACK or read with NACK), STOP.
// Open-drain lines are expressed as output-enables; 1 pulls the line low.
module i2c_controller
  import i2c_pkg::*;
#(
  parameter int CLK_DIV = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] addr,
  input  logic              rw,
  input  logic [7:0]        wdata,
  input  logic              sda_i,
  output logic              scl_oe,
  output logic              sda_oe,
  output logic              busy,
  output logic              done,
  output logic              ack_err,
  output logic [7:0]        rdata
);

  state_t     r_state;
  logic [2:0] r_bit_cnt;
  logic [7:0] r_tx_shift;
  logic [7:0] r_wdata;
  logic [7:0] r_rx_shift;
  logic       r_rw;
  logic       r_sda_smp;

  logic       w_idle;
  logic       w_qtick;
  logic [1:0] w_quarter;
  logic       w_slot_end;
  logic       w_sample;
  logic       w_scl_low_q;
  logic       w_scl_nxt;
  logic       w_sda_nxt;

  assign w_idle      = (r_state == IDLE);
  assign w_slot_end  = w_qtick && (w_quarter == 2'd3);
  assign w_sample    = w_qtick && (w_quarter == 2'd1);
  assign w_scl_low_q = (w_quarter == 2'd0) || (w_quarter == 2'd3);

  i2c_tick_gen #(
    .CLK_DIV(CLK_DIV)
  ) u_tick_gen (
    .i_clk    (clk),
    .i_rst    (rst),
    .i_clear  (w_idle),
    .o_qtick  (w_qtick),
    .o_quarter(w_quarter)
  );

  // Line levels for the current quarter; registered below, so edges land one cycle into each quarter.
  always_comb begin
    w_scl_nxt = 1'b0;
    w_sda_nxt = 1'b0;
    case (r_state)
      START: begin
        w_sda_nxt = 1'b1;
        w_scl_nxt = w_quarter[1];
      end
      ADDR, WRITE: begin
        w_sda_nxt = ~r_tx_shift[7];
        w_scl_nxt = w_scl_low_q;
      end
      ADDR_ACK, WRITE_ACK, READ, READ_NACK: begin
        w_scl_nxt = w_scl_low_q;
      end
      STOP: begin
        w_sda_nxt = ~w_quarter[1];
        w_scl_nxt = (w_quarter == 2'd0);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state    <= IDLE;
      r_bit_cnt  <= 3'd0;
      r_tx_shift <= 8'h00;
      r_wdata    <= 8'h00;
      r_rx_shift <= 8'h00;
      r_rw       <= RW_WRITE;
      r_sda_smp  <= 1'b1;
      scl_oe     <= 1'b0;
      sda_oe     <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      ack_err    <= 1'b0;
      rdata      <= 8'h00;
    end else begin
      done   <= 1'b0;
      scl_oe <= w_scl_nxt;
      sda_oe <= w_sda_nxt;
      if (w_sample) begin
        r_sda_smp <= sda_i;
      end

      case (r_state)
        IDLE: begin
          // A start coinciding with the done pulse is dropped, not deferred.
          if (start && !done) begin
            r_tx_shift <= {addr, rw};
            r_rw       <= rw;
            r_wdata    <= wdata;
            r_bit_cnt  <= 3'd0;
            busy       <= 1'b1;
            ack_err    <= 1'b0;
            r_state    <= START;
          end
        end
        START: begin
          if (w_slot_end) begin
            r_state <= ADDR;
          end
        end
        ADDR: begin
          if (w_slot_end) begin
            r_tx_shift <= {r_tx_shift[6:0], 1'b0};
            if (r_bit_cnt == 3'd7) begin
              r_bit_cnt <= 3'd0;
              r_state   <= ADDR_ACK;
            end else begin
              r_bit_cnt <= r_bit_cnt + 3'd1;
            end
          end
        end
        ADDR_ACK: begin
          if (w_slot_end) begin
            if (r_sda_smp) begin
              ack_err <= 1'b1;
              r_state <= STOP;
            end else if (r_rw == RW_READ) begin
              r_state <= READ;
            end else begin
              r_tx_shift <= r_wdata;
              r_state    <= WRITE;
            end
          end
        end
        WRITE: begin
          if (w_slot_end) begin
            r_tx_shift <= {r_tx_shift[6:0], 1'b0};
            if (r_bit_cnt == 3'd7) begin
              r_bit_cnt <= 3'd0;
              r_state   <= WRITE_ACK;
            end else begin
              r_bit_cnt <= r_bit_cnt + 3'd1;
            end
          end
        end
        WRITE_ACK: begin
          if (w_slot_end) begin
            if (r_sda_smp) begin
              ack_err <= 1'b1;
            end
            r_state <= STOP;
          end
        end
        READ: begin
          if (w_sample) begin
            r_rx_shift <= {r_rx_shift[6:0], sda_i};
          end
          if (w_slot_end) begin
            if (r_bit_cnt == 3'd7) begin
              r_bit_cnt <= 3'd0;
              r_state   <= READ_NACK;
            end else begin
              r_bit_cnt <= r_bit_cnt + 3'd1;
            end
          end
        end
        READ_NACK: begin
          if (w_slot_end) begin
            r_state <= STOP;
          end
        end
        STOP: begin
          if (w_slot_end) begin
            if (r_rw == RW_READ && !ack_err) begin
              rdata <= r_rx_shift;
            end
            done    <= 1'b1;
            busy    <= 1'b0;
            r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_i2c_controller.sv
// Bench for i2c_controller: behavioural target, bus protocol watcher and a done-driven scoreboard.
module tb_i2c_controller;
  import i2c_pkg::*;

  localparam int CLK_DIV = 4;
  localparam int SLOT    = 4 * CLK_DIV;

  typedef struct {
    logic [7:0]  rdata;
    logic        ackErr;
    int          lat;
    int          rises;
    logic [31:0] bits;
    int          acc;
    int          startBase;
    int          stopBase;
    int          violBase;
  } expEntry;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [6:0] addr;
  logic       rw;
  logic [7:0] wdata;
  logic       sclOe, sdaOe, busy, done, ackErr;
  logic [7:0] rdata;

  logic       sclBus, sdaBus;
  logic       tgtDrive = 1'b0;
  logic       tgtRw = 1'b0, tgtAckAddr = 1'b0, tgtAckData = 1'b0;
  logic [7:0] tgtByte = 8'h00;
  logic       checkEn = 1'b0;
  logic       inFrame = 1'b0;
  logic       prevScl = 1'b1, prevSda = 1'b1;
  logic [31:0] seenBits = '0;
  int         nRises = 0, startCnt = 0, stopCnt = 0, violations = 0;

  int         cycleCnt = 0, doneCnt = 0, doneBase = 0;
  int         assertCnt = 0, failCnt = 0;
  logic [7:0] lastRdata = 8'h00;
  expEntry    sb[$];

  assign sclBus = ~sclOe;
  assign sdaBus = ~(sdaOe | tgtDrive);

  i2c_controller #(.CLK_DIV(CLK_DIV)) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .addr   (addr),
    .rw     (rw),
    .wdata  (wdata),
    .sda_i  (sdaBus),
    .scl_oe (sclOe),
    .sda_oe (sdaOe),
    .busy   (busy),
    .done   (done),
    .ack_err(ackErr),
    .rdata  (rdata)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cycleCnt <= cycleCnt + 1;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    assertCnt++;
    if (got !== exp) begin
      failCnt++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, got, exp, cycleCnt);
    end
  endtask

  // Target response for the slot that follows the nth SCL rise of the frame.
  function automatic logic targetDrive(input int n);
    logic [2:0] idx;
    idx = 3'(16 - n);
    if (n == 8) return tgtAckAddr;
    if (tgtRw && tgtAckAddr && n >= 9 && n <= 16) return ~tgtByte[idx];
    if (!tgtRw && tgtAckAddr && n == 17) return tgtAckData;
    return 1'b0;
  endfunction

  // Target model and protocol watcher: SDA may move with SCL high only as START or STOP.
  always @(sclBus or sdaBus) begin
    if (!checkEn) inFrame = 1'b0;
    if (sclBus !== prevScl) begin
      prevScl = sclBus;
      if (sclBus === 1'b1) begin
        seenBits = {seenBits[30:0], sdaBus};
        nRises++;
      end else if (sclBus === 1'b0) begin
        tgtDrive = targetDrive(nRises);
      end
    end else if (sdaBus !== prevSda && checkEn && sclBus === 1'b1) begin
      if (sdaBus === 1'b0) begin
        if (inFrame) violations++;
        inFrame  = 1'b1;
        startCnt++;
        nRises   = 0;
        seenBits = '0;
      end else begin
        if (!inFrame) violations++;
        inFrame = 1'b0;
        stopCnt++;
      end
    end
    prevSda = sdaBus;
  end

  always @(negedge clk) begin
    if (rst === 1'b1 && done === 1'b1) begin
      expEntry e;
      doneCnt++;
      if (sb.size() == 0) begin
        checkOutput("unexpectedDone", 32'(sb.size()), 32'd1);
      end else begin
        e = sb.pop_front();
        checkOutput("rdata", rdata, e.rdata);
        checkOutput("ackErr", ackErr, e.ackErr);
        checkOutput("latency", 32'(cycleCnt - e.acc), 32'(e.lat));
        checkOutput("busyAtDone", busy, 1'b0);
        checkOutput("sclIdle", sclOe, 1'b0);
        checkOutput("sdaIdle", sdaOe, 1'b0);
        checkOutput("sclRises", 32'(nRises), 32'(e.rises));
        checkOutput("sdaBits", seenBits, e.bits);
        checkOutput("startCount", 32'(startCnt - e.startBase), 32'd1);
        checkOutput("stopCount", 32'(stopCnt - e.stopBase), 32'd1);
        checkOutput("protocol", 32'(violations - e.violBase), 32'd0);
      end
    end
  end

  task automatic applyStimulus(input logic [6:0] a, input logic r, input logic [7:0] wd,
                               input logic ackA, input logic ackD, input logic [7:0] rb);
    expEntry e;
    @(negedge clk);
    addr = a; rw = r; wdata = wd;
    tgtRw = r; tgtAckAddr = ackA; tgtAckData = ackD; tgtByte = rb;
    e.startBase = startCnt;
    e.stopBase  = stopCnt;
    e.violBase  = violations;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    e.acc    = cycleCnt;
    e.ackErr = !ackA || (r == RW_WRITE && !ackD);
    e.lat    = SLOT * (ackA ? 20 : 11);
    e.rises  = ackA ? 19 : 10;
    if (!ackA)           e.bits = 32'({a, r, 1'b1, 1'b0});
    else if (r == RW_READ) e.bits = 32'({a, 1'b1, 1'b0, rb, 1'b1, 1'b0});
    else                 e.bits = 32'({a, 1'b0, 1'b0, wd, ~ackD, 1'b0});
    if (r == RW_READ && ackA) lastRdata = rb;
    e.rdata = lastRdata;
    sb.push_back(e);
    checkOutput("busyOnAccept", busy, 1'b1);
  endtask

  task automatic waitDone();
    for (int i = 0; i < 2000 && sb.size() != 0; i++) @(negedge clk);
    if (sb.size() != 0) begin
      checkOutput("doneTimeout", 32'(sb.size()), 32'd0);
      sb.delete();
    end
  endtask

  initial begin
    logic [6:0] ra;
    logic [7:0] rwd, rrb;
    logic       rrw, rack;

    rst = 1'b0; start = 1'b0; addr = '0; rw = 1'b0; wdata = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("rstScl", sclOe, 1'b0);
    checkOutput("rstSda", sdaOe, 1'b0);
    checkOutput("rstBusy", busy, 1'b0);
    checkOutput("rstDone", done, 1'b0);
    checkOutput("rstAckErr", ackErr, 1'b0);
    checkOutput("rstRdata", rdata, 8'h00);
    rst = 1'b1;
    checkEn = 1'b1;
    repeat (2) @(negedge clk);

    applyStimulus(7'h5A, RW_WRITE, 8'hC3, 1'b1, 1'b1, 8'h00); waitDone();
    applyStimulus(7'h21, RW_READ,  8'h00, 1'b1, 1'b1, 8'h96); waitDone();
    applyStimulus(7'h10, RW_WRITE, 8'hFF, 1'b0, 1'b0, 8'h00); waitDone();
    applyStimulus(7'h33, RW_WRITE, 8'h0F, 1'b1, 1'b0, 8'h00); waitDone();

    // start during an active transfer, then start in the done cycle: both must be dropped
    applyStimulus(7'h44, RW_WRITE, 8'hA5, 1'b1, 1'b1, 8'h00);
    repeat (50) @(negedge clk);
    addr = 7'h7F; rw = RW_READ; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    checkOutput("busyIgnoredStart", busy, 1'b1);
    for (int i = 0; i < 2000 && done !== 1'b1; i++) @(negedge clk);
    checkOutput("doneSeen", done, 1'b1);
    addr = 7'h0A; rw = RW_WRITE; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    checkOutput("startOnDoneIgnored", busy, 1'b0);
    waitDone();
    applyStimulus(7'h21, RW_READ, 8'h00, 1'b1, 1'b1, 8'h5C); waitDone();

    // reset during data bit 3 of a write: lines released, no done, bus usable afterwards
    applyStimulus(7'h3C, RW_WRITE, 8'h81, 1'b1, 1'b1, 8'h00);
    repeat (13 * SLOT + 4) @(negedge clk);
    checkEn = 1'b0;
    rst = 1'b0;
    sb.delete();
    lastRdata = 8'h00;
    doneBase = doneCnt;
    @(posedge clk);
    #1;
    checkOutput("midRstScl", sclOe, 1'b0);
    checkOutput("midRstSda", sdaOe, 1'b0);
    checkOutput("midRstBusy", busy, 1'b0);
    checkOutput("midRstDone", done, 1'b0);
    checkOutput("midRstRdata", rdata, 8'h00);
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    checkEn = 1'b1;
    repeat (400) @(negedge clk);
    checkOutput("noDoneAfterReset", 32'(doneCnt - doneBase), 32'd0);
    applyStimulus(7'h3C, RW_WRITE, 8'h81, 1'b1, 1'b1, 8'h00); waitDone();

    for (int i = 0; i < 4; i++) begin
      ra   = 7'($urandom_range(0, 127));
      rrw  = 1'($urandom_range(0, 1));
      rwd  = 8'($urandom_range(0, 255));
      rrb  = 8'($urandom_range(0, 255));
      rack = 1'($urandom_range(0, 1));
      applyStimulus(ra, rrw, rwd, 1'b1, rack, rrb);
      waitDone();
    end

    repeat (5) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", assertCnt, failCnt);
    $finish;
  end

endmodule

// File: doc/i2c_controller.md
I2C_CONTROLLER -- requirements
Module: i2c_controller

Interface
REQ-001 Parameter CLK_DIV, default 4, clk cycles per quarter SCL period; legal range is 2 or greater, giving an SCL period of 4*CLK_DIV clk cycles.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst  input  1  synchronous, active-low reset.
REQ-004 start  input  1  request a single-byte transaction; accepted only when busy=0.
REQ-005 addr  input  7  target address; sampled on accept.
REQ-006 rw  input  1  0=write, 1=read; sampled on accept.
REQ-007 wdata  input  8  write byte; sampled on accept.
REQ-008 sda_i  input  1  resolved SDA bus level (assumed synchronized externally).
REQ-009 scl_oe  output  1  1 = drive SCL low, 0 = release (bus pulled high).
REQ-010 sda_oe  output  1  1 = drive SDA low, 0 = release.
REQ-011 busy  output  1  high from accept cycle through STOP completion.
REQ-012 done  output  1  single-cycle pulse at transaction end.
REQ-013 ack_err  output  1  set when target NACKs address or write data; valid with done, held until next accept.
REQ-014 rdata  output  8  received byte, MSB first; updated at done of read transaction, held otherwise.

Function
REQ-015 Bit timing: every bit slot is 4 quarters Q0..Q3 of CLK_DIV cycles each; SDA changes only in Q0 with SCL low, SCL released in Q1, SDA sampled at start of Q2, SCL driven low in Q3.
REQ-016 FSM states: IDLE, START, ADDR, ADDR_ACK, WRITE, WRITE_ACK, READ, READ_NACK, STOP.
REQ-017 IDLE: scl_oe=0, sda_oe=0; on start=1, latch addr/rw/wdata, set busy, clear ack_err, enter START next cycle.
REQ-018 START (one slot): SDA driven low while SCL released (Q0-Q1), SCL driven low from Q2.
REQ-019 ADDR: 8 slots shifting {addr,rw} MSB first; bit 1 releases SDA, bit 0 drives low.
REQ-020 ADDR_ACK: SDA released; sampled sda_i=1 sets ack_err and goes to STOP; 0 goes to WRITE (rw=0) or READ (rw=1).
REQ-021 WRITE: 8 slots of wdata MSB first; WRITE_ACK samples sda_i, 1 sets ack_err; either way then STOP.
REQ-022 READ: SDA released, 8 slots, sda_i shifted in MSB first; READ_NACK: controller releases SDA (NACK, single-byte read), then STOP.
REQ-023 STOP (one slot): SDA driven low in Q0, SCL released in Q1, SDA released in Q2; SDA rising with SCL high forms STOP.
REQ-024 At end of STOP slot: done=1 for one cycle, busy=0, return to IDLE; new start accepted the cycle after done.
REQ-025 Latency: write or read = 20 slots, address-NACK = 11 slots; done asserted in cycle 4*CLK_DIV*slots after the accept cycle.
REQ-026 start while busy=1 is ignored, not queued; start in the same cycle as done is ignored.
REQ-027 No clock stretching, arbitration, repeated START, or multi-byte bursts; a target holding SCL low is not detected.
REQ-028 Bit and quarter counters wrap only through FSM transitions; no counter overflows silently.

Reset
REQ-029 rst=0 at any clock edge forces IDLE; scl_oe=0, sda_oe=0, busy=0, done=0, ack_err=0, rdata=0, all counters 0.
REQ-030 Reset mid-transaction releases both lines at the next edge, with no STOP generated; the transaction is abandoned without a done pulse.

Structure
REQ-031 Package i2c_pkg holds the FSM state enum, RW_WRITE/RW_READ constants, and the address width 7; the existing target block shares this package.
REQ-032 One sub-module, i2c_tick_gen: a CLK_DIV divider emitting a quarter-tick pulse and a 2-bit quarter index, cleared on rst and when idle.

Verification
REQ-033 Write, CLK_DIV=4, addr=0x5A, wdata=0xC3, target ACKs both bytes -> SDA bit sequence on SCL rises is 1011010 0 A 11000011 A; done in cycle 320; ack_err=0.
REQ-034 Read, addr=0x21, target ACKs and returns 0x96 -> controller NACKs; rdata=0x96 at done in cycle 320; ack_err=0.
REQ-035 Address NACK: target silent (sda_i=1), addr=0x10 -> no data phase, STOP issued, done in cycle 176 with ack_err=1.
REQ-036 start pulsed at cycle 50 of an active transaction -> ignored; exactly one done; a second start after done runs normally.
REQ-037 rst=0 during WRITE bit 3 -> next edge scl_oe=0, sda_oe=0, busy=0, no done; a following transaction completes correctly.
REQ-038 Protocol checker on every run: SDA changes only while SCL low, except START (high-to-low with SCL high) and STOP (low-to-high with SCL high).
